auv_csru: RTL
=============

Name: auv_csru

Overview:
CSR execution unit in the EX stage. It runs CSRRW/CSRRS/CSRRC(I) instructions as the initiator on the CSR bus, doing read-modify-write sequences against the trap-controller responder. It stalls the pipeline until the access completes, returns the old CSR value for writeback, and raises an illegal-CSR exception for unmapped or unacknowledged addresses.

Parameters:
CBUS_BASE, 12'h300, 12-bit CSR address of the 128-entry window mapped onto the CSR bus; must be 128-aligned.
ACK_TIMEOUT, 3, cycles waited for cbus_ack after a request before declaring the CSR unimplemented; range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_req  in  1  EX holds a CSR instruction; held until done/exc pulse
csr_op  in  2  01 RW, 10 RS, 11 RC; 00 treated as RW
csr_addr  in  12  CSR number from instruction
csr_wdata  in  32  rs1 value or zero-extended uimm
rd_nz  in  1  rd != x0
rs1_nz  in  1  rs1/uimm field != 0
flush  in  1  pipeline flush from trap controller
stall  out  1  hold pipeline
done  out  1  one-cycle completion pulse
csr_rdata  out  32  old CSR value; valid with done
exc_illegal_inst_csr  out  1  one-cycle illegal-CSR pulse
cbus_sel  out  1  bus select, one-cycle strobe
cbus_adr  out  7  csr_addr[6:0]
cbus_dat_wr  out  32  write data
cbus_rd  out  1  read strobe
cbus_wr  out  1  write strobe
cbus_dat_rd  in  32  read data, valid with cbus_ack
cbus_ack  in  1  responder ack, earliest one cycle after the strobe

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs are 0 asynchronously (stall, done, exc, cbus_* strobes, csr_rdata, cbus_dat_wr, cbus_adr).
- Decode: mapped = (csr_addr[11:7] == CBUS_BASE[11:7]).
- need_rd = rd_nz | (op != RW). need_wr = (op == RW) | rs1_nz.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR.
- IDLE, csr_req & ~flush:
  - not mapped -> ERR.
  - else need_rd -> RD_REQ.
  - else -> WR_REQ.
- RD_REQ: cbus_sel = cbus_rd = 1 for exactly this cycle -> RD_WAIT. Timeout counter cleared.
- RD_WAIT, on cbus_ack:
  - latch old = cbus_dat_rd.
  - new = RW: wdata; RS: old | wdata; RC: old & ~wdata.
  - need_wr -> WR_REQ, else -> DONE.
- RD_WAIT, no ack: counter increments; counter reaching ACK_TIMEOUT -> ERR.
- WR_REQ: cbus_sel = cbus_wr = 1 and cbus_dat_wr = new (or wdata when there was no read) for one cycle -> WR_WAIT.
- WR_WAIT: ack -> DONE; timeout -> ERR.
- DONE: done = 1, csr_rdata = old (0 if no read was performed), stall = 0 -> IDLE.
- ERR: exc_illegal_inst_csr = 1, stall = 0 -> IDLE. No bus strobe is ever issued for an unmapped address.
- cbus_rd and cbus_wr are never asserted in the same cycle. Strobes are single-cycle so the registered-ack responder produces exactly one ack per access.
- stall = (IDLE & csr_req & ~flush) | (state in RD_REQ, RD_WAIT, WR_REQ, WR_WAIT). stall is combinational.
- Latency with 1-cycle ack:
  - read+write: done on the 5th cycle after csr_req.
  - read-only or write-only: done on the 3rd cycle.
- flush:
  - in IDLE, RD_REQ, RD_WAIT: abort to IDLE with no done/exc. A late ack arriving in IDLE is ignored.
  - in WR_REQ, WR_WAIT: ignored; the write commits and done still pulses.
- Acks arriving in IDLE, DONE or ERR are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all strobes low. A pending responder ack after reset release is ignored.
- Back-to-back instructions: a new csr_req is accepted in IDLE on the cycle after DONE/ERR.

Test Plan:
1. CSRRW addr 0x305, wdata 0x100, rd_nz=1, responder holds 0x40 -> rd strobe adr 0x05 at cycle 1; wr strobe dat 0x100 at cycle 3; done at cycle 5 with csr_rdata 0x40; stall high for cycles 0-4.
2. CSRRS 0x300, rs1_nz=0, old 0x88 -> single read strobe, no cbus_wr ever; done at cycle 3, csr_rdata 0x88.
3. CSRRC 0x304, old 0x880, wdata 0x080 -> cbus_dat_wr 0x800; CSRRS same old with wdata 0x008 -> 0x888.
4. CSRRW 0xC00 -> exc_illegal_inst_csr pulse at cycle 1; cbus_sel never asserted; done never pulses.
5. CSRRS 0x346 with responder never acking, ACK_TIMEOUT=3 -> one rd strobe then exc pulse after 3 wait cycles; next csr_req accepted normally. Flush in RD_WAIT -> IDLE, no pulses, late ack ignored.
6. CSRRW 0x341, rd_nz=0 -> write-only, done at cycle 3 with csr_rdata 0. rst_n low during WR_WAIT -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/auv_csru.sv
// auv_csru: EX-stage CSR unit doing read-modify-write accesses over the CSR bus.
// Ports: clk/rst_n; csr_req/csr_op/csr_addr/csr_wdata/rd_nz/rs1_nz/flush from EX;
// stall/done/csr_rdata/exc_illegal_inst_csr back to the pipeline;
// cbus_sel/cbus_adr/cbus_dat_wr/cbus_rd/cbus_wr strobes out, cbus_dat_rd/cbus_ack in.
module auv_csru #(
  parameter logic [11:0] CBUS_BASE   = 12'h300,
  parameter int          ACK_TIMEOUT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        rd_nz,
  input  logic        rs1_nz,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] csr_rdata,
  output logic        exc_illegal_inst_csr,
  output logic        cbus_sel,
  output logic [6:0]  cbus_adr,
  output logic [31:0] cbus_dat_wr,
  output logic        cbus_rd,
  output logic        cbus_wr,
  input  logic [31:0] cbus_dat_rd,
  input  logic        cbus_ack
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR} state_t;
  localparam logic [3:0] TO = 4'(ACK_TIMEOUT);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] old_q, old_nx, new_q, new_nx, mod_val;
  logic mapped, is_rw, need_rd, need_wr, timeout;
  assign mapped  = csr_addr[11:7] == CBUS_BASE[11:7];
  assign is_rw   = ~csr_op[1];
  assign need_rd = rd_nz | ~is_rw;
  assign need_wr = is_rw | rs1_nz;
  assign timeout = cnt + 4'd1 == TO;
  assign mod_val = is_rw ? csr_wdata : csr_op[0] ? cbus_dat_rd & ~csr_wdata : cbus_dat_rd | csr_wdata;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    old_nx   = old_q;
    new_nx   = new_q;
    case (state)
      IDLE: if (csr_req && !flush) begin
        old_nx   = '0;
        new_nx   = csr_wdata;
        state_nx = !mapped ? ERR : need_rd ? RD_REQ : WR_REQ;
      end
      RD_REQ: begin
        cnt_nx   = '0;
        state_nx = flush ? IDLE : RD_WAIT;
      end
      RD_WAIT: if (flush) state_nx = IDLE;
      else if (cbus_ack) begin
        old_nx   = cbus_dat_rd;
        new_nx   = mod_val;
        state_nx = need_wr ? WR_REQ : DONE;
      end else begin
        cnt_nx   = cnt + 4'd1;
        state_nx = timeout ? ERR : RD_WAIT;
      end
      WR_REQ: begin
        cnt_nx   = '0;
        state_nx = WR_WAIT;
      end
      WR_WAIT: if (cbus_ack) state_nx = DONE;
      else begin
        cnt_nx   = cnt + 4'd1;
        state_nx = timeout ? ERR : WR_WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      old_q <= '0;
      new_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      old_q <= old_nx;
      new_q <= new_nx;
    end
  // rst_n gates stall so every output is low while reset is held, even with csr_req high
  assign stall = rst_n & ((state == IDLE & csr_req & ~flush) | state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT});
  assign done                 = state == DONE;
  assign exc_illegal_inst_csr = state == ERR;
  assign csr_rdata            = done ? old_q : '0;
  assign cbus_rd              = state == RD_REQ;
  assign cbus_wr              = state == WR_REQ;
  assign cbus_sel             = cbus_rd | cbus_wr;
  assign cbus_dat_wr          = cbus_wr ? new_q : '0;
  assign cbus_adr             = cbus_sel ? csr_addr[6:0] : '0;
endmodule
